// File: rtl/ptr_unit_pkg.sv
// rtl/ptr_unit_pkg.sv - shared post-mode encodings and select-width helper for ptr_unit
package ptr_unit_pkg;

  localparam logic [1:0] PM_NONE = 2'b00;
  localparam logic [1:0] PM_INC  = 2'b01;
  localparam logic [1:0] PM_DEC  = 2'b10;

  // Width of the pointer index for n pointer registers (n >= 2).
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ptr_unit_if.sv
// rtl/ptr_unit_if.sv - access/write bus between the instruction decode and ptr_unit
interface ptr_unit_if #(
  parameter int MDATAW = 8,
  parameter int NPTR   = 4
) ();
  import ptr_unit_pkg::*;

  localparam int SELW = sel_width(NPTR);

  logic [SELW-1:0]   sel;
  logic [MDATAW-1:0] din;
  logic              wr_ptr;
  logic              wr_len;
  logic              use_en;
  logic [1:0]        post;
  logic              rev;
  logic [MDATAW-1:0] ptr_o;
  logic              srf_o;
  logic              inv_o;

  modport master (
    output sel, din, wr_ptr, wr_len, use_en, post, rev,
    input  ptr_o, srf_o, inv_o
  );

  modport slave (
    input  sel, din, wr_ptr, wr_len, use_en, post, rev,
    output ptr_o, srf_o, inv_o
  );

endinterface

// File: rtl/ptr_unit_ptr_next.sv
// rtl/ptr_unit_ptr_next.sv - next-pointer computation with linear or circular wrap
module ptr_next
  import ptr_unit_pkg::*;
#(
  parameter int MDATAW = 8
) (
  input  logic [MDATAW-1:0] p,
  input  logic [MDATAW-1:0] l,
  input  logic [1:0]        post,
  output logic [MDATAW-1:0] nxt
);

  localparam logic [MDATAW-1:0] ONE  = MDATAW'(1);
  localparam logic [MDATAW-1:0] ZERO = '0;

  // L==0 is linear (natural modulo wrap); otherwise wrap within [0, L-1],
  // pulling any out-of-range pointer back into the window.
  always_comb begin
    nxt = p;
    case (post)
      PM_INC: begin
        if (l == ZERO)           nxt = p + ONE;
        else if (p >= l - ONE)   nxt = ZERO;
        else                     nxt = p + ONE;
      end
      PM_DEC: begin
        if (l == ZERO)                  nxt = p - ONE;
        else if (p == ZERO || p >= l)   nxt = l - ONE;
        else                            nxt = p - ONE;
      end
      default: nxt = p;
    endcase
  end

endmodule

// File: rtl/ptr_unit.sv
// rtl/ptr_unit.sv - pointer/length register file with post-modify and registered output stage
module ptr_unit
  import ptr_unit_pkg::*;
#(
  parameter int MDATAW = 8,
  parameter int FFTSIZ = 3,
  parameter int USEFFT = 1,
  parameter int NPTR   = 4
) (
  input logic        clk,
  input logic        rst,
  ptr_unit_if.slave  bus
);

  localparam int  SELW    = sel_width(NPTR);
  localparam bit  FFT_ON  = (USEFFT != 0);

  // FFTSIZ only travels with the design to the bit-reverse stage; sanity-check it here.
  if (FFTSIZ < 1 || FFTSIZ > MDATAW) begin : g_fftsiz_chk
    $error("ptr_unit: FFTSIZ must be within 1..MDATAW");
  end
  if (NPTR < 2 || (1 << SELW) != NPTR) begin : g_nptr_chk
    $error("ptr_unit: NPTR must be a power of two >= 2");
  end

  logic [MDATAW-1:0] p_q [NPTR];
  logic [MDATAW-1:0] p_d [NPTR];
  logic [MDATAW-1:0] l_q [NPTR];
  logic [MDATAW-1:0] l_d [NPTR];
  logic [MDATAW-1:0] ptr_q, ptr_d;
  logic              srf_q, srf_d;
  logic              inv_q, inv_d;

  logic [MDATAW-1:0] cur_p;
  logic [MDATAW-1:0] cur_l;
  logic [MDATAW-1:0] nxt_p;

  // Read the selected pointer and length before any update this cycle.
  always_comb begin
    cur_p = p_q[bus.sel];
    cur_l = l_q[bus.sel];
  end

  ptr_next #(.MDATAW(MDATAW)) u_ptr_next (
    .p    (cur_p),
    .l    (cur_l),
    .post (bus.post),
    .nxt  (nxt_p)
  );

  // Write decode and priority: wr_ptr overrides the post-modify; wr_len is independent.
  always_comb begin
    p_d   = p_q;
    l_d   = l_q;
    ptr_d = ptr_q;
    srf_d = 1'b0;
    inv_d = 1'b0;
    if (bus.use_en) begin
      ptr_d          = cur_p;
      srf_d          = 1'b1;
      inv_d          = bus.rev & FFT_ON;
      p_d[bus.sel]   = nxt_p;
    end
    if (bus.wr_ptr) p_d[bus.sel] = bus.din;
    if (bus.wr_len) l_d[bus.sel] = bus.din;
  end

  // State and output registers; reset clears everything including an in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTR; i++) begin
        p_q[i] <= '0;
        l_q[i] <= '0;
      end
      ptr_q <= '0;
      srf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      l_q   <= l_d;
      ptr_q <= ptr_d;
      srf_q <= srf_d;
      inv_q <= inv_d;
    end
  end

  assign bus.ptr_o = ptr_q;
  assign bus.srf_o = srf_q;
  assign bus.inv_o = inv_q;

endmodule

// File: tb/tb_ptr_unit.sv
// tb/tb_ptr_unit.sv - table-driven scoreboard bench for ptr_unit (USEFFT=1 and USEFFT=0)
module tb_ptr_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ptr_unit_if #(.MDATAW(8), .NPTR(4)) bus_a ();
  ptr_unit_if #(.MDATAW(8), .NPTR(4)) bus_b ();

  ptr_unit #(.MDATAW(8), .FFTSIZ(3), .USEFFT(1), .NPTR(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  ptr_unit #(.MDATAW(8), .FFTSIZ(3), .USEFFT(0), .NPTR(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  assign bus_b.sel    = bus_a.sel;
  assign bus_b.din    = bus_a.din;
  assign bus_b.wr_ptr = bus_a.wr_ptr;
  assign bus_b.wr_len = bus_a.wr_len;
  assign bus_b.use_en = bus_a.use_en;
  assign bus_b.post   = bus_a.post;
  assign bus_b.rev    = bus_a.rev;

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic [7:0] din;
    logic       wp;
    logic       wl;
    logic       use_en;
    logic [1:0] post;
    logic       rev;
    logic [7:0] eptr;
    logic       esrf;
    logic       einv;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] eptr;
    logic       esrf;
    logic       einv;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] s, input logic [7:0] d,
                              input logic wp, input logic wl, input logic u,
                              input logic [1:0] pm, input logic rv,
                              input logic [7:0] ep, input logic es, input logic ei);
    vec_t v;
    v.rst = r; v.sel = s; v.din = d; v.wp = wp; v.wl = wl; v.use_en = u;
    v.post = pm; v.rev = rv; v.eptr = ep; v.esrf = es; v.einv = ei;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, record the expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst           = v.rst;
    bus_a.sel     = v.sel;
    bus_a.din     = v.din;
    bus_a.wr_ptr  = v.wp;
    bus_a.wr_len  = v.wl;
    bus_a.use_en  = v.use_en;
    bus_a.post    = v.post;
    bus_a.rev     = v.rev;
    exp_q.push_back('{idx: step_no, eptr: v.eptr, esrf: v.esrf, einv: v.einv});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ptr_o",      e.idx, bus_a.ptr_o, e.eptr);
    check("srf_o",      e.idx, {7'd0, bus_a.srf_o}, {7'd0, e.esrf});
    check("inv_o",      e.idx, {7'd0, bus_a.inv_o}, {7'd0, e.einv});
    check("nofft_ptr",  e.idx, bus_b.ptr_o, e.eptr);
    check("nofft_srf",  e.idx, {7'd0, bus_b.srf_o}, {7'd0, e.esrf});
    check("nofft_inv",  e.idx, {7'd0, bus_b.inv_o}, 8'd0);
    step_no++;
  endtask

  initial begin
    //            rst  sel   din    wp wl use post   rev  eptr   srf inv
    vecs.push_back(mk(1, 2'd0, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    // reset overrides a simultaneous access
    vecs.push_back(mk(0, 2'd2, 8'h35, 1, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 2'd2, 8'h00, 0, 0, 1, 2'b00, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b00, 0, 8'h00, 1, 0));
    // linear wrap
    vecs.push_back(mk(0, 2'd0, 8'hFF, 1, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 0, 1, 2'b01, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 0, 1, 2'b01, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 0, 1, 2'b00, 0, 8'h01, 1, 0));
    // circular increment, L=5
    vecs.push_back(mk(0, 2'd1, 8'h05, 0, 1, 0, 2'b00, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h03, 1, 0, 0, 2'b00, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h03, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h04, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h01, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h02, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b01, 0, 8'h03, 1, 0));
    // circular decrement from out of range
    vecs.push_back(mk(0, 2'd1, 8'h09, 1, 0, 0, 2'b00, 0, 8'h03, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b10, 0, 8'h09, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b10, 0, 8'h04, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b10, 0, 8'h03, 1, 0));
    // wr_ptr + wr_len together, then increment at the top of the window
    vecs.push_back(mk(0, 2'd2, 8'h06, 1, 1, 0, 2'b00, 0, 8'h03, 0, 0));
    vecs.push_back(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b01, 0, 8'h06, 1, 0));
    vecs.push_back(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b00, 0, 8'h00, 1, 0));
    // same-cycle wr_ptr beats post-modify, old P presented
    vecs.push_back(mk(0, 2'd3, 8'h10, 1, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'd3, 8'h80, 1, 0, 1, 2'b01, 0, 8'h10, 1, 0));
    vecs.push_back(mk(0, 2'd3, 8'h00, 0, 0, 1, 2'b00, 0, 8'h80, 1, 0));
    // wr_len in the same cycle: modify uses old L=5 (P 2 -> 3)
    vecs.push_back(mk(0, 2'd1, 8'h03, 0, 1, 1, 2'b01, 0, 8'h02, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b00, 0, 8'h03, 1, 0));
    // bit-reverse flag aligned with ptr_o; dropped without access
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b00, 1, 8'h03, 1, 1));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 0, 2'b00, 1, 8'h03, 0, 0));
    // unselected pointer 0 untouched
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 0, 1, 2'b00, 0, 8'h01, 1, 0));
    // reset mid-sequence discards the access and clears state
    vecs.push_back(mk(1, 2'd0, 8'h00, 0, 0, 1, 2'b01, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b00, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b10, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b00, 0, 8'hFF, 1, 0));
    // circular decrement from 0 wraps to L-1
    vecs.push_back(mk(0, 2'd1, 8'h04, 0, 1, 0, 2'b00, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 1, 0, 0, 2'b00, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b10, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'd1, 8'h00, 0, 0, 1, 2'b00, 0, 8'h03, 1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: L=2 window on pointer 2, back-to-back increments and reserved post=11.
    apply(mk(0, 2'd2, 8'h02, 1, 1, 0, 2'b00, 0, 8'h03, 0, 0));
    apply(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b01, 0, 8'h02, 1, 0));
    apply(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b01, 0, 8'h00, 1, 0));
    apply(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b11, 0, 8'h01, 1, 0));
    apply(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b01, 1, 8'h01, 1, 1));
    apply(mk(0, 2'd2, 8'h00, 0, 0, 1, 2'b00, 0, 8'h00, 1, 0));

    // Hand sequence: write then access next cycle presents din; wr_ptr without use keeps ptr_o.
    apply(mk(0, 2'd3, 8'hA5, 1, 0, 0, 2'b00, 0, 8'h00, 0, 0));
    apply(mk(0, 2'd3, 8'h00, 0, 0, 1, 2'b10, 0, 8'hA5, 1, 0));
    apply(mk(0, 2'd3, 8'h00, 0, 0, 1, 2'b00, 0, 8'hA4, 1, 0));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
